// File: rtl/instruction_fetch_if.sv
// Signal bundle between the fetch stage, its instruction memory and decode.
// The master modport is the fetch unit and the slave modport is its environment.
interface instruction_fetch_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  stall;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_data;
  logic                  if_valid;
  logic [DATA_WIDTH-1:0] if_instr;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic [ADDR_WIDTH-1:0] if_pc_plus1;

  modport master (
    input  stall, redirect, redirect_pc, imem_data,
    output imem_addr, if_valid, if_instr, if_pc, if_pc_plus1
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_data,
    input  imem_addr, if_valid, if_instr, if_pc, if_pc_plus1
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives a 1-cycle-latency instruction memory and
// registers each returned word together with its address into IF/ID.
module instruction_fetch #(
  parameter int                  ADDR_WIDTH = 10,
  parameter int                  DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input logic                  clk,
  input logic                  rst,
  instruction_fetch_if.master  bus
);
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  req_valid_q, req_valid_d;
  logic                  if_valid_q, if_valid_d;
  logic [DATA_WIDTH-1:0] if_instr_q, if_instr_d;
  logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;

  // While stalled, re-issue the outstanding address so imem_data stays stable.
  assign bus.imem_addr   = (bus.stall && !bus.redirect) ? req_pc_q : pc_q;
  assign bus.if_valid    = if_valid_q;
  assign bus.if_instr    = if_instr_q;
  assign bus.if_pc       = if_pc_q;
  assign bus.if_pc_plus1 = if_pc_q + ADDR_WIDTH'(1);

  always_comb begin
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = req_valid_q;
    if_valid_d  = if_valid_q;
    if_instr_d  = if_instr_q;
    if_pc_d     = if_pc_q;
    if (bus.redirect) begin
      pc_d        = bus.redirect_pc;
      req_valid_d = 1'b0;
      if_valid_d  = 1'b0;
    end else if (!bus.stall) begin
      if_valid_d  = req_valid_q;
      if_instr_d  = bus.imem_data;
      if_pc_d     = req_pc_q;
      req_pc_d    = pc_q;
      req_valid_d = 1'b1;
      pc_d        = pc_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      req_valid_q <= 1'b0;
      if_valid_q  <= 1'b0;
      if_instr_q  <= '0;
      if_pc_q     <= '0;
    end else begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      if_valid_q  <= if_valid_d;
      if_instr_q  <= if_instr_d;
      if_pc_q     <= if_pc_d;
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a synchronous-read memory model
// preloaded as mem[i] = A000_0000 + i.
module tb_instruction_fetch;
  logic clk;
  logic rst;

  instruction_fetch_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

  instruction_fetch #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .RESET_PC(10'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: samples the address at the edge, data valid until the next edge.
  always @(posedge clk) bus.imem_data <= 32'hA000_0000 + 32'(bus.imem_addr);

  typedef struct {
    bit       rst;
    bit       stall;
    bit       redir;
    int       rpc;
    bit       chk_addr;
    int       exp_addr;
    bit       exp_valid;
    bit       chk_pc;
    int       exp_pc;
  } vec_t;

  vec_t tbl[$];
  int   checks;
  int   errors;

  function automatic vec_t mk(bit r, bit s, bit d, int rpc, bit ca, int ea,
                              bit ev, bit cp, int ep);
    vec_t v;
    v.rst = r; v.stall = s; v.redir = d; v.rpc = rpc;
    v.chk_addr = ca; v.exp_addr = ea;
    v.exp_valid = ev; v.chk_pc = cp; v.exp_pc = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [31:0] exp_instr;
    rst = v.rst;
    bus.stall = v.stall;
    bus.redirect = v.redir;
    bus.redirect_pc = 10'(v.rpc);
    #1;
    if (v.chk_addr) chk($sformatf("v%0d_imem_addr", idx), 32'(bus.imem_addr), 32'(v.exp_addr));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_if_valid", idx), 32'(bus.if_valid), 32'(v.exp_valid));
    if (v.chk_pc) begin
      exp_instr = v.rst ? 32'h0 : 32'hA000_0000 + 32'(v.exp_pc);
      chk($sformatf("v%0d_if_pc", idx), 32'(bus.if_pc), 32'(v.exp_pc));
      chk($sformatf("v%0d_if_instr", idx), bus.if_instr, exp_instr);
      chk($sformatf("v%0d_if_pc_plus1", idx), 32'(bus.if_pc_plus1), 32'((v.exp_pc + 1) % 1024));
    end
    $display("vec %0d: rst=%0b stall=%0b redir=%0b rpc=%0d -> addr=%0d valid=%0b pc=%0d instr=%h",
             idx, v.rst, v.stall, v.redir, v.rpc, bus.imem_addr, bus.if_valid, bus.if_pc, bus.if_instr);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;

    // Reset then run
    tbl.push_back(mk(1,0,0,0,    0,0,    0,0,0));
    tbl.push_back(mk(1,0,0,0,    1,0,    0,1,0));
    tbl.push_back(mk(0,0,0,0,    1,0,    0,0,0));
    tbl.push_back(mk(0,0,0,0,    1,1,    1,1,0));
    tbl.push_back(mk(0,0,0,0,    1,2,    1,1,1));
    tbl.push_back(mk(0,0,0,0,    1,3,    1,1,2));
    tbl.push_back(mk(0,0,0,0,    1,4,    1,1,3));
    tbl.push_back(mk(0,0,0,0,    1,5,    1,1,4));
    tbl.push_back(mk(0,0,0,0,    1,6,    1,1,5));
    // Stall for three cycles at if_pc=5
    tbl.push_back(mk(0,1,0,0,    1,6,    1,1,5));
    tbl.push_back(mk(0,1,0,0,    1,6,    1,1,5));
    tbl.push_back(mk(0,1,0,0,    1,6,    1,1,5));
    tbl.push_back(mk(0,0,0,0,    1,7,    1,1,6));
    tbl.push_back(mk(0,0,0,0,    1,8,    1,1,7));
    tbl.push_back(mk(0,0,0,0,    1,9,    1,1,8));
    // Redirect to 100
    tbl.push_back(mk(0,0,1,100,  1,10,   0,1,8));
    tbl.push_back(mk(0,0,0,0,    1,100,  0,0,0));
    tbl.push_back(mk(0,0,0,0,    1,101,  1,1,100));
    tbl.push_back(mk(0,0,0,0,    1,102,  1,1,101));
    // Redirect to 10, then redirect to 20 while stalled
    tbl.push_back(mk(0,0,1,10,   1,103,  0,1,101));
    tbl.push_back(mk(0,0,0,0,    1,10,   0,0,0));
    tbl.push_back(mk(0,0,0,0,    1,11,   1,1,10));
    tbl.push_back(mk(0,1,0,0,    1,11,   1,1,10));
    tbl.push_back(mk(0,1,1,20,   1,12,   0,1,10));
    tbl.push_back(mk(0,1,0,0,    1,11,   0,1,10));
    tbl.push_back(mk(0,0,0,0,    1,20,   0,0,0));
    tbl.push_back(mk(0,0,0,0,    1,21,   1,1,20));
    tbl.push_back(mk(0,0,0,0,    1,22,   1,1,21));
    // Wrap-around
    tbl.push_back(mk(0,0,1,1022, 1,23,   0,1,21));
    tbl.push_back(mk(0,0,0,0,    1,1022, 0,0,0));
    tbl.push_back(mk(0,0,0,0,    1,1023, 1,1,1022));
    tbl.push_back(mk(0,0,0,0,    1,0,    1,1,1023));
    tbl.push_back(mk(0,0,0,0,    1,1,    1,1,0));
    tbl.push_back(mk(0,0,0,0,    1,2,    1,1,1));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Reset mid-stream while stalled at if_pc=40
    apply(mk(0,0,1,40, 0,0,  0,0,0),  100);
    apply(mk(0,0,0,0,  1,40, 0,0,0),  101);
    apply(mk(0,0,0,0,  1,41, 1,1,40), 102);
    apply(mk(0,1,0,0,  1,41, 1,1,40), 103);
    apply(mk(1,1,0,0,  1,41, 0,1,0),  104);
    rst = 1'b0;
    #1;
    chk("post_rst_stalled_imem_addr", 32'(bus.imem_addr), 32'd0);
    apply(mk(0,0,0,0,  1,0,  0,0,0),  105);
    apply(mk(0,0,0,0,  1,1,  1,1,0),  106);
    apply(mk(0,0,0,0,  1,2,  1,1,1),  107);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
